// File: rtl/sym_pkg.sv
// Shared constants for the symbol-sequence transmitter: FSM state encodings
// and the default hold symbol.
package sym_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] IDLE_SYM_DEF = 2'b00;

endpackage

// File: rtl/sym_seq_tx_if.sv
// Command and symbol-stream bundle of sym_seq_tx. The "repeat" field is carried
// as repeat_n because repeat is a reserved word in SystemVerilog.
interface sym_seq_tx_if #(
  parameter int NSYM = 8
) ();
  localparam int IDX_W = $clog2(NSYM);

  logic                  start;
  logic                  abort;
  logic [2*NSYM-1:0]     pattern;
  logic [2:0]            gap;
  logic [3:0]            repeat_n;
  logic                  x1;
  logic                  x0;
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      sym_idx;

  modport master (
    output start, abort, pattern, gap, repeat_n,
    input  x1, x0, busy, done, sym_idx
  );

  modport slave (
    input  start, abort, pattern, gap, repeat_n,
    output x1, x0, busy, done, sym_idx
  );
endinterface

// File: rtl/tx_down_counter.sv
// Loadable down-counter with zero flag; decrement stops at zero.
module tx_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sym_seq_tx.sv
// Frame transmitter driving the (x1, x0) symbol stream: sends NSYM captured
// symbols per frame, optional hold gaps between symbols, repeat_n+1 frames.
module sym_seq_tx
  import sym_pkg::*;
#(
  parameter int         NSYM     = 8,
  parameter logic [1:0] IDLE_SYM = IDLE_SYM_DEF
) (
  input  logic          clk,
  input  logic          reset,
  sym_seq_tx_if.slave   bus
);

  localparam int IDX_W = $clog2(NSYM);
  localparam int PAT_W = 2 * NSYM;

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [2:0]       gap_q;
  logic [1:0]       sym_q, sym_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cap, adv, last_idx;
  logic             gap_load, gap_dec, gap_zero;
  logic             frm_load, frm_dec, frm_zero;

  // Non-destructive selection: the captured frame is reused for every repeat.
  function automatic logic [1:0] sym_at(input logic [PAT_W-1:0] p,
                                        input logic [IDX_W-1:0] i);
    return p[{i, 1'b0} +: 2];
  endfunction

  assign idx_inc  = idx_q + IDX_W'(1);
  assign last_idx = (idx_q == IDX_W'(NSYM - 1));

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cap      = 1'b0;
    adv      = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    frm_load = 1'b0;
    frm_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sym_d  = IDLE_SYM;
        idx_d  = '0;
        busy_d = 1'b0;
        if (bus.start && !bus.abort) begin
          cap      = 1'b1;
          frm_load = 1'b1;
          state_d  = ST_SEND;
          sym_d    = bus.pattern[1:0];
          busy_d   = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          sym_d   = IDLE_SYM;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (last_idx && frm_zero) begin
          state_d = ST_DONE;
          sym_d   = IDLE_SYM;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_q != 3'd0) begin
          // Counter holds gap-1 so its zero flag marks the final gap cycle.
          state_d  = ST_GAP;
          sym_d    = IDLE_SYM;
          gap_load = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          sym_d   = IDLE_SYM;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (gap_zero) begin
          adv = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sym_d   = IDLE_SYM;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        sym_d   = IDLE_SYM;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (adv) begin
      state_d = ST_SEND;
      idx_d   = idx_inc;
      sym_d   = sym_at(pat_q, idx_inc);
      frm_dec = last_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sym_q   <= 2'b00;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (cap) gap_q <= bus.gap;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) pat_q <= bus.pattern;
  end

  tx_down_counter #(.W(3)) u_gap_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (gap_load),
    .load_val (gap_q - 3'd1),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  tx_down_counter #(.W(4)) u_frm_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (frm_load),
    .load_val (bus.repeat_n),
    .dec      (frm_dec),
    .zero     (frm_zero)
  );

  assign bus.x1      = sym_q[1];
  assign bus.x0      = sym_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sym_idx = idx_q;

endmodule

// File: tb/tb_sym_seq_tx.sv
// Scoreboard bench for sym_seq_tx (NSYM=8): per-cycle expected symbol stream
// is queued when a transmission starts and compared as the DUT produces it.
module tb_sym_seq_tx;

  typedef struct packed {
    logic [1:0] x;
    logic       busy;
    logic       done;
    logic [2:0] idx;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];

  sym_seq_tx_if #(.NSYM(8)) bus ();

  sym_seq_tx #(.NSYM(8), .IDLE_SYM(2'b00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_x"},    {30'd0, bus.x1, bus.x0}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy},       32'd0);
    check({tag, "_done"}, {31'd0, bus.done},       32'd0);
  endtask

  task automatic build_expected(input logic [15:0] pat, input logic [2:0] g, input logic [3:0] r);
    exp_t e;
    exp_q.delete();
    for (int f = 0; f <= int'(r); f++) begin
      for (int i = 0; i < 8; i++) begin
        e.x = pat[2*i +: 2]; e.busy = 1'b1; e.done = 1'b0; e.idx = i[2:0];
        exp_q.push_back(e);
        if (!(f == int'(r) && i == 7)) begin
          for (int j = 0; j < int'(g); j++) begin
            e.x = 2'b00;
            exp_q.push_back(e);
          end
        end
      end
    end
    e = '{x: 2'b00, busy: 1'b0, done: 1'b1, idx: 3'd0};
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic run_tx(input logic [15:0] pat, input logic [2:0] g, input logic [3:0] r,
                        input int restart_at, input int abort_at);
    exp_t e;
    int   k;
    int   nbusy;
    build_expected(pat, g, r);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b0;
    bus.pattern = pat; bus.gap = g; bus.repeat_n = r;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    nbusy = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("x",    {30'd0, bus.x1, bus.x0}, {30'd0, e.x});
      check("busy", {31'd0, bus.busy},       {31'd0, e.busy});
      check("done", {31'd0, bus.done},       {31'd0, e.done});
      if (e.busy) check("sym_idx", {29'd0, bus.sym_idx}, {29'd0, e.idx});
      if (bus.busy) nbusy++;
      // Inputs scrambled after capture must not disturb the frame.
      bus.pattern  = 16'($urandom);
      bus.gap      = 3'($urandom);
      bus.repeat_n = 4'($urandom);
      bus.start    = (k == restart_at);
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_quiet("abort");
        exp_q.delete();
        @(posedge clk); #1;
        check_quiet("post_abort");
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    bus.start = 1'b0;
    check("busy_cycles", nbusy, (int'(r) + 1) * 8 * (int'(g) + 1) - int'(g));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pattern = '0; bus.gap = '0; bus.repeat_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_idx", {29'd0, bus.sym_idx}, 32'd0);
    reset = 1'b1;

    run_tx(16'h00E4, 3'd0, 4'd0, -1, -1);
    run_tx(16'h00E4, 3'd2, 4'd0, -1, -1);
    run_tx(16'h00E4, 3'd0, 4'd2, -1, -1);
    run_tx(16'h9C36, 3'd1, 4'd1, -1, -1);
    run_tx(16'hB1E4, 3'd0, 4'd0, 3, 5);
    run_tx(16'h5AF0, 3'd3, 4'd0, 2, 12);

    for (int t = 0; t < 3; t++) begin
      run_tx(16'($urandom), 3'($urandom_range(0, 3)), 4'($urandom_range(0, 1)), -1, -1);
    end

    // start and abort together in IDLE: nothing starts.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.abort = 1'b1; bus.pattern = 16'hFFFF; bus.gap = 3'd0; bus.repeat_n = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_quiet("start_abort");
    end
    bus.start = 1'b0; bus.abort = 1'b0;

    // Asynchronous reset between edges during a gap.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.pattern = 16'h00E7; bus.gap = 3'd2; bus.repeat_n = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rst_sym0", {30'd0, bus.x1, bus.x0}, 32'd3);
    @(posedge clk); #1;
    check("rst_gap_busy", {31'd0, bus.busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_idx", {29'd0, bus.sym_idx}, 32'd0);
    @(posedge clk); #1;
    check_quiet("reset_held");
    reset = 1'b1;
    run_tx(16'h00E7, 3'd1, 4'd0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sym_seq_tx.md
SYM_SEQ_TX -- requirements
Module: sym_seq_tx

Transmitter that drives the 2-bit symbol stream (x1, x0) consumed by the team's sequence-detector FSM. x0=0 is the "hold" symbol.

Interface
REQ-001 Parameter NSYM, 8, symbols per frame (power of 2, 2..16).
REQ-002 Parameter IDLE_SYM, 2'b00, symbol driven whenever not in SEND.
REQ-003 Port clk  input  1  sole clock, rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request to begin transmission, sampled on clk.
REQ-006 Port abort  input  1  synchronous abort of the current transmission.
REQ-007 Port pattern  input  2*NSYM  frame symbols; symbol i = pattern[2i+1:2i], symbol 0 sent first.
REQ-008 Port gap  input  3  hold-symbol cycles inserted after each symbol.
REQ-009 Port repeat  input  4  extra frames; total frames = repeat+1.
REQ-010 Port x1  output  1  symbol MSB, registered.
REQ-011 Port x0  output  1  symbol LSB, registered.
REQ-012 Port busy  output  1  high from the first SEND cycle through the last SEND/GAP cycle.
REQ-013 Port done  output  1  one-cycle pulse after normal completion.
REQ-014 Port sym_idx  output  log2(NSYM)  index of the symbol currently on x1/x0.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP, DONE.
REQ-016 In IDLE with start=1 and abort=0, the block SHALL capture pattern, gap and repeat and enter SEND on the same edge.
REQ-017 Symbol 0 SHALL appear on x1/x0 in the cycle immediately after the edge that sampled start (latency 1).
REQ-018 Each SEND cycle SHALL drive exactly one symbol for one cycle, then go to GAP if captured gap>0, else to SEND with the next symbol.
REQ-019 GAP SHALL last exactly gap cycles driving IDLE_SYM; sym_idx SHALL hold the last sent index.
REQ-020 Gap cycles SHALL follow every symbol except the final symbol of the final frame.
REQ-021 After symbol NSYM-1, sym_idx SHALL wrap to 0; the captured pattern is resent if frames remain.
REQ-022 After the final symbol, the FSM SHALL enter DONE for one cycle (done=1, busy=0, x=IDLE_SYM), then IDLE.
REQ-023 Total busy cycles SHALL equal (repeat+1)*NSYM*(gap+1) - gap.
REQ-024 start SHALL be ignored while busy=1 or in DONE; input changes after capture SHALL NOT affect the transmission.
REQ-025 abort=1 in SEND or GAP SHALL force IDLE on the next edge, with x=IDLE_SYM, busy=0 and no done pulse.
REQ-026 start and abort both high in IDLE SHALL leave the FSM in IDLE (abort wins).
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, x1=0, x0=0, busy=0, done=0, sym_idx=0, and clear all counters, including mid-transmission.
REQ-029 After reset is released, the first start SHALL behave per REQ-016/REQ-017.

Structure
REQ-030 The state encoding constants and the IDLE_SYM default SHALL live in the shared package sym_pkg.
REQ-031 The gap and frame counters SHALL use one reusable sub-module, tx_down_counter (load, decrement, zero flag; width parameter).
REQ-032 The pattern SHALL be held in a 2*NSYM capture register; the symbol SHALL be selected by sym_idx, and the register SHALL NOT be shifted destructively.

Verification (NSYM=8)
REQ-033 pattern=16'h00E4, gap=0, repeat=0, start pulse -> x = 00,01,10,11,00,00,00,00 over 8 cycles; busy high 8 cycles; done high in cycle 9 only.
REQ-034 Same pattern with gap=2 -> each symbol is followed by two 00 cycles except the last; busy high 22 cycles; then done.
REQ-035 repeat=2, gap=0 -> 24 symbol cycles; sym_idx goes 0..7 three times; one done pulse.
REQ-036 start re-asserted at symbol 3 -> ignored, sequence unchanged; abort at symbol 5 -> next cycle x=00, busy=0, no done.
REQ-037 start=abort=1 in IDLE -> busy stays 0, x stays 00.
REQ-038 reset driven 0 between clock edges during GAP -> outputs are 0 immediately; the next start after release yields symbol 0 with 1-cycle latency.
